// File: rtl/bram_rd_arbiter.sv
// Round-robin arbiter sharing one BRAM read port among NB_REQ requesters.
// Define BRAM_RD_ARBITER_RSP_REG_EN to register the response outputs (3-cycle latency).
module bram_rd_arbiter #(
    parameter int NB_REQ     = 4,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 64
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         arb_en,
    input  logic [NB_REQ-1:0]            req_valid,
    input  logic [ADDR_WIDTH*NB_REQ-1:0] req_addr,
    output logic [NB_REQ-1:0]            req_ready,
    output logic                         rden,
    output logic [ADDR_WIDTH-1:0]        rdaddr,
    input  logic [DATA_WIDTH-1:0]        rddata,
    output logic [NB_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]        rsp_data
);

    localparam int PW = $clog2(NB_REQ);

    logic [PW-1:0]         r_ptr;
    logic                  r_rden;
    logic [ADDR_WIDTH-1:0] r_rdaddr;
    logic [NB_REQ-1:0]     r_id1;
    logic [NB_REQ-1:0]     r_id2;

    logic [NB_REQ-1:0]     w_gnt;
    logic [PW-1:0]         w_gnt_idx;
    logic                  w_gnt_any;
    logic [PW-1:0]         w_ptr_nxt;
    logic [ADDR_WIDTH-1:0] w_gnt_addr;
    logic [DATA_WIDTH-1:0] w_rsp_data;

    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NB_REQ) s = s - NB_REQ;
        return PW'(s);
    endfunction

    // Search upward from the pointer, wrapping; reset also blocks grants.
    always_comb begin
        w_gnt     = '0;
        w_gnt_idx = '0;
        w_gnt_any = 1'b0;
        if (arb_en && aresetn) begin
            for (int k = 0; k < NB_REQ; k++) begin
                if (!w_gnt_any && req_valid[wrap_idx(r_ptr, k)]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_idx = wrap_idx(r_ptr, k);
                end
            end
        end
        if (w_gnt_any) w_gnt[w_gnt_idx] = 1'b1;
    end

    assign w_ptr_nxt  = (w_gnt_idx == PW'(NB_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    assign w_gnt_addr = req_addr[ADDR_WIDTH*w_gnt_idx +: ADDR_WIDTH];

    // The one-hot id doubles as the valid flag of each pipeline stage.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_ptr    <= '0;
            r_rden   <= 1'b0;
            r_rdaddr <= '0;
            r_id1    <= '0;
            r_id2    <= '0;
        end else begin
            r_rden <= w_gnt_any;
            r_id1  <= w_gnt;
            r_id2  <= r_id1;
            if (w_gnt_any) begin
                r_ptr    <= w_ptr_nxt;
                r_rdaddr <= w_gnt_addr;
            end
        end
    end

    assign req_ready  = w_gnt;
    assign rden       = r_rden;
    assign rdaddr     = r_rdaddr;
    assign w_rsp_data = (|r_id2) ? rddata : '0;

`ifdef BRAM_RD_ARBITER_RSP_REG_EN
    logic [NB_REQ-1:0]     r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= r_id2;
            r_rsp_data  <= w_rsp_data;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
`else
    assign rsp_valid = r_id2;
    assign rsp_data  = w_rsp_data;
`endif

endmodule
